// File: rtl/trap_ctrl_if.sv
// rtl/trap_ctrl_if.sv - pipeline-to-trap-controller bundle (events, CSR port, redirect)
interface trap_ctrl_if;
    logic        exc_valid;
    logic [31:0] exc_cause;
    logic        mret_valid;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        irq_ext;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    modport master (
        output exc_valid, exc_cause, mret_valid, mem_valid, mem_pc, irq_ext,
               csr_addr, csr_we, csr_wdata,
        input  csr_rdata, flush, redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  exc_valid, exc_cause, mret_valid, mem_valid, mem_pc, irq_ext,
               csr_addr, csr_we, csr_wdata,
        output csr_rdata, flush, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap/MRET controller with CSR file and flush/redirect FSM
module trap_ctrl #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter logic        MIE_RST   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    trap_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FLUSH, REDIR} state_e;

    state_e      state_q;
    logic        mstatus_mie_q;
    logic        mstatus_mpie_q;
    logic        meie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] target_q;
    logic        flush_q;
    logic        redir_q;
    logic        busy_q;
    logic [31:0] rpc_q;

    logic idle;
    logic irq_pend;
    logic take_exc;
    logic take_mret;
    logic take_irq;
    logic csr_ok;

    always_comb begin
        idle      = (state_q == IDLE);
        irq_pend  = bus.irq_ext & mstatus_mie_q & meie_q & bus.mem_valid;
        take_exc  = idle & bus.exc_valid;
        take_mret = idle & bus.mret_valid & ~bus.exc_valid;
        take_irq  = idle & irq_pend & ~bus.exc_valid & ~bus.mret_valid;
        csr_ok    = idle & bus.csr_we & ~take_exc & ~take_mret & ~take_irq;
    end

    always_comb begin
        bus.csr_rdata = 32'h0;
        case (bus.csr_addr)
            12'h300: bus.csr_rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
            12'h304: bus.csr_rdata = {20'b0, meie_q, 11'b0};
            12'h305: bus.csr_rdata = mtvec_q;
            12'h340: bus.csr_rdata = mscratch_q;
            12'h341: bus.csr_rdata = mepc_q;
            12'h342: bus.csr_rdata = mcause_q;
            12'h344: bus.csr_rdata = {20'b0, bus.irq_ext, 11'b0};
            default: bus.csr_rdata = 32'h0;
        endcase
    end

    assign bus.flush          = flush_q;
    assign bus.redirect_valid = redir_q;
    assign bus.redirect_pc    = rpc_q;
    assign bus.busy           = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            mstatus_mie_q  <= MIE_RST;
            mstatus_mpie_q <= 1'b0;
            meie_q         <= 1'b0;
            mtvec_q        <= {MTVEC_RST[31:2], 2'b00};
            mscratch_q     <= 32'h0;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
            target_q       <= 32'h0;
            flush_q        <= 1'b0;
            redir_q        <= 1'b0;
            busy_q         <= 1'b0;
            rpc_q          <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take_exc || take_irq) begin
                        mepc_q         <= {bus.mem_pc[31:2], 2'b00};
                        mcause_q       <= take_exc ? bus.exc_cause : 32'h8000_000B;
                        mstatus_mpie_q <= mstatus_mie_q;
                        mstatus_mie_q  <= 1'b0;
                        target_q       <= mtvec_q;
                        state_q        <= FLUSH;
                        flush_q        <= 1'b1;
                        busy_q         <= 1'b1;
                    end else if (take_mret) begin
                        mstatus_mie_q  <= mstatus_mpie_q;
                        mstatus_mpie_q <= 1'b1;
                        target_q       <= mepc_q;
                        state_q        <= FLUSH;
                        flush_q        <= 1'b1;
                        busy_q         <= 1'b1;
                    end else if (csr_ok) begin
                        // mip is read-only and unknown addresses fall through silently
                        case (bus.csr_addr)
                            12'h300: begin
                                mstatus_mie_q  <= bus.csr_wdata[3];
                                mstatus_mpie_q <= bus.csr_wdata[7];
                            end
                            12'h304: meie_q     <= bus.csr_wdata[11];
                            12'h305: mtvec_q    <= {bus.csr_wdata[31:2], 2'b00};
                            12'h340: mscratch_q <= bus.csr_wdata;
                            12'h341: mepc_q     <= {bus.csr_wdata[31:2], 2'b00};
                            12'h342: mcause_q   <= bus.csr_wdata;
                            default: ;
                        endcase
                    end
                end
                FLUSH: begin
                    state_q <= REDIR;
                    redir_q <= 1'b1;
                    rpc_q   <= target_q;
                end
                REDIR: begin
                    state_q <= IDLE;
                    flush_q <= 1'b0;
                    redir_q <= 1'b0;
                    busy_q  <= 1'b0;
                    rpc_q   <= 32'h0;
                end
                default: begin
                    state_q <= IDLE;
                    flush_q <= 1'b0;
                    redir_q <= 1'b0;
                    busy_q  <= 1'b0;
                    rpc_q   <= 32'h0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - scoreboard bench for trap_ctrl: redirect and CSR-read queues checked by a monitor
module tb_trap_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic rd_strobe = 1'b0;
    logic prev_flush = 1'b0;
    logic prev_rv = 1'b0;

    typedef struct { logic [31:0] pc; int cyc; } redir_t;
    typedef struct { logic [11:0] addr; logic [31:0] val; } rd_t;
    redir_t exp_q[$];
    rd_t    rd_q[$];

    trap_ctrl_if bus ();

    trap_ctrl #(.MTVEC_RST(32'h0), .MIE_RST(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a redirect or a read is tagged
    always @(negedge clk) begin
        if (bus.redirect_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_redirect", bus.redirect_pc, 32'hxxxx_xxxx);
            end else begin
                redir_t e;
                e = exp_q.pop_front();
                chk("redirect_pc", bus.redirect_pc, e.pc);
                chk("redirect_cycle", cyc, e.cyc);
                chk("redirect_flush_busy", {30'b0, bus.flush, bus.busy}, 32'h3);
                chk("flush_before_redir", {30'b0, prev_flush, prev_rv}, 32'h2);
            end
        end
        if (rd_strobe) begin
            if (rd_q.size() == 0) begin
                chk("read_queue_underflow", 32'h1, 32'h0);
            end else begin
                rd_t r;
                r = rd_q.pop_front();
                chk($sformatf("csr_%h", r.addr), bus.csr_rdata, r.val);
            end
        end
        prev_flush = bus.flush;
        prev_rv    = bus.redirect_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_evt();
        bus.exc_valid  = 1'b0;
        bus.exc_cause  = 32'h0;
        bus.mret_valid = 1'b0;
        bus.mem_valid  = 1'b0;
        bus.mem_pc     = 32'h0;
        bus.irq_ext    = 1'b0;
        bus.csr_we     = 1'b0;
        bus.csr_wdata  = 32'h0;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        bus.csr_addr  = a;
        bus.csr_wdata = d;
        bus.csr_we    = 1'b1;
        step();
        bus.csr_we    = 1'b0;
    endtask

    task automatic read_chk(input logic [11:0] a, input logic [31:0] v);
        bus.csr_addr = a;
        rd_q.push_back('{a, v});
        rd_strobe = 1'b1;
        step();
        rd_strobe = 1'b0;
    endtask

    task automatic out_chk(input string name, input logic f, input logic r, input logic b);
        @(negedge clk);
        chk({name, "_ctl"}, {29'b0, bus.flush, bus.redirect_valid, bus.busy}, {29'b0, f, r, b});
        if (!r) chk({name, "_pc"}, bus.redirect_pc, 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] tgt);
        exp_q.push_back('{tgt, cyc + 2});
        step();
        clear_evt();
    endtask

    task automatic evt_wait();
        out_chk("flush_n1", 1'b1, 1'b0, 1'b1);
        step();
        out_chk("idle_n3", 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        clear_evt();
        bus.csr_addr = 12'h0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        out_chk("reset", 1'b0, 1'b0, 1'b0);
        read_chk(12'h300, 32'h0000_1800);
        read_chk(12'h305, 32'h0);
        read_chk(12'h7C0, 32'h0);

        // exception to freshly written mtvec
        csr_write(12'h305, 32'h100);
        bus.exc_valid = 1'b1; bus.exc_cause = 32'd11; bus.mem_valid = 1'b1; bus.mem_pc = 32'h40;
        issue(32'h100);
        evt_wait();
        read_chk(12'h341, 32'h40);
        read_chk(12'h342, 32'd11);
        read_chk(12'h300, 32'h0000_1800);

        // mret right after mepc write
        csr_write(12'h300, 32'h80);
        read_chk(12'h300, 32'h0000_1880);
        csr_write(12'h341, 32'h44);
        bus.mret_valid = 1'b1; bus.mem_valid = 1'b1;
        issue(32'h44);
        evt_wait();
        read_chk(12'h300, 32'h0000_1888);

        // external interrupt
        csr_write(12'h304, 32'hFFFF_FFFF);
        read_chk(12'h304, 32'h800);
        bus.irq_ext = 1'b1; bus.mem_valid = 1'b1; bus.mem_pc = 32'h80;
        issue(32'h100);
        evt_wait();
        read_chk(12'h342, 32'h8000_000B);
        read_chk(12'h341, 32'h80);
        read_chk(12'h300, 32'h0000_1880);
        bus.irq_ext = 1'b1; bus.mem_valid = 1'b1;
        repeat (4) step();
        read_chk(12'h344, 32'h800);
        csr_write(12'h344, 32'h0);
        read_chk(12'h344, 32'h800);
        clear_evt();
        read_chk(12'h344, 32'h0);

        // exception beats interrupt and same-cycle CSR write
        csr_write(12'h340, 32'h1234);
        csr_write(12'h300, 32'h8);
        read_chk(12'h300, 32'h0000_1808);
        bus.exc_valid = 1'b1; bus.exc_cause = 32'd2; bus.irq_ext = 1'b1; bus.mem_valid = 1'b1;
        bus.mem_pc = 32'h90; bus.csr_addr = 12'h340; bus.csr_we = 1'b1; bus.csr_wdata = 32'hDEAD;
        issue(32'h100);
        evt_wait();
        read_chk(12'h342, 32'd2);
        read_chk(12'h341, 32'h90);
        read_chk(12'h340, 32'h1234);

        // mtvec low bits, events and writes during FLUSH ignored
        csr_write(12'h305, 32'h203);
        read_chk(12'h305, 32'h200);
        bus.exc_valid = 1'b1; bus.exc_cause = 32'd11; bus.mem_valid = 1'b1; bus.mem_pc = 32'h50;
        exp_q.push_back('{32'h200, cyc + 2});
        step();
        bus.exc_valid = 1'b1; bus.exc_cause = 32'd5; bus.mem_pc = 32'h54;
        bus.csr_addr = 12'h340; bus.csr_we = 1'b1; bus.csr_wdata = 32'h5555;
        step();
        clear_evt();
        step();
        out_chk("idle_after_pulse", 1'b0, 1'b0, 1'b0);
        read_chk(12'h342, 32'd11);
        read_chk(12'h341, 32'h50);
        read_chk(12'h340, 32'h1234);

        // reset during REDIR
        bus.exc_valid = 1'b1; bus.exc_cause = 32'd11; bus.mem_valid = 1'b1; bus.mem_pc = 32'h60;
        issue(32'h200);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_chk("rst_in_redir", 1'b0, 1'b0, 1'b0);
        read_chk(12'h341, 32'h0);
        read_chk(12'h305, 32'h0);
        read_chk(12'h342, 32'h0);

        // reset during FLUSH: no redirect may follow
        bus.exc_valid = 1'b1; bus.exc_cause = 32'd11; bus.mem_valid = 1'b1; bus.mem_pc = 32'h70;
        step();
        clear_evt();
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_chk("rst_in_flush", 1'b0, 1'b0, 1'b0);
        read_chk(12'h300, 32'h0000_1800);

        repeat (5) step();
        chk("redir_queue_empty", exp_q.size(), 32'd0);
        chk("read_queue_empty", rd_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL provide parameter MTVEC_RST, default 32'h0000_0000, reset value of mtvec.
REQ-002 SHALL provide parameter MIE_RST, default 1'b0, reset value of mstatus.MIE.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 exc_valid  in  1  MEM-stage instruction raises a synchronous exception (ECALL).
REQ-006 exc_cause  in  32  cause code for exc_valid.
REQ-007 mret_valid  in  1  MEM-stage instruction is MRET.
REQ-008 mem_valid  in  1  MEM stage holds a real (non-bubble) instruction.
REQ-009 mem_pc  in  32  PC of the MEM-stage instruction.
REQ-010 irq_ext  in  1  external interrupt request, level-sensitive.
REQ-011 csr_addr  in  12  CSR address from MEM stage.
REQ-012 csr_we  in  1  CSR write enable; new value already computed by the CSR ALU.
REQ-013 csr_wdata  in  32  CSR write data.
REQ-014 csr_rdata  out  32  combinational read of csr_addr; 0 for unimplemented addresses.
REQ-015 flush  out  1  squash IF/ID/EX/MEM pipeline registers.
REQ-016 redirect_valid  out  1  load PC with redirect_pc.
REQ-017 redirect_pc  out  32  PC target.
REQ-018 busy  out  1  high when FSM is not IDLE; the hazard unit stalls fetch.

Function
REQ-019 CSRs SHALL be: mstatus 0x300 (MIE bit3, MPIE bit7, MPP[12:11] hardwired 2'b11, other bits 0), mie 0x304 (only MEIE bit11 writable), mtvec 0x305 (bits[1:0] hardwired 0), mscratch 0x340, mepc 0x341 (bits[1:0] hardwired 0), mcause 0x342, mip 0x344 (bit11 = irq_ext, read-only, writes ignored).
REQ-020 FSM states SHALL be IDLE, FLUSH, REDIR.
REQ-021 Events are sampled only in IDLE; priority exc_valid > mret_valid > interrupt; exactly one event is accepted per cycle.
REQ-022 An interrupt is pending when irq_ext & mstatus.MIE & mie.MEIE & mem_valid.
REQ-023 On accepted exception at edge T: mepc<=mem_pc, mcause<=exc_cause, MPIE<=MIE, MIE<=0, target<=mtvec, state<=FLUSH.
REQ-024 On accepted interrupt at edge T: mepc<=mem_pc, mcause<=32'h8000_000B, MPIE<=MIE, MIE<=0, target<=mtvec, state<=FLUSH.
REQ-025 On accepted mret at edge T: MIE<=MPIE, MPIE<=1, target<=mepc, state<=FLUSH.
REQ-026 FLUSH: flush=1, redirect_valid=0, next state REDIR unconditionally.
REQ-027 REDIR: flush=1, redirect_valid=1, redirect_pc=target, next state IDLE unconditionally.
REQ-028 Latency: event in cycle N -> flush in N+1 and N+2, redirect_valid in N+2 only, IDLE in N+3.
REQ-029 In IDLE: flush=0, redirect_valid=0, redirect_pc=0, busy=0; busy=1 in FLUSH and REDIR.
REQ-030 csr_we SHALL update the addressed CSR only in IDLE with no event accepted that cycle; otherwise the write is dropped.
REQ-031 Inputs exc_valid, mret_valid, irq_ext, csr_we SHALL be ignored in FLUSH and REDIR.
REQ-032 A mepc or mtvec CSR write in cycle N followed by an event in N+1 SHALL use the written value.
REQ-033 csr_rdata SHALL reflect CSR state updates from the prior edge, not same-cycle writes.

Reset
REQ-034 On rst: state=IDLE, mstatus.MIE=MIE_RST, MPIE=0, mie=0, mtvec=MTVEC_RST, mepc=0, mcause=0, mscratch=0, target=0; all outputs at IDLE values.
REQ-035 rst asserted in FLUSH or REDIR SHALL abort the sequence; no redirect is issued after reset.

Verification
REQ-036 Write mtvec=0x100 then exc_valid=1, exc_cause=11, mem_pc=0x40 -> flush N+1..N+2, redirect_pc=0x100 at N+2, mepc=0x40, mcause=11, MIE=0.
REQ-037 mstatus.MPIE=1, mepc=0x44, mret_valid=1 -> redirect_pc=0x44 at N+2, MIE=1, MPIE=1.
REQ-038 MIE=1, mie=0x800, irq_ext=1, mem_valid=1, mem_pc=0x80 -> mcause=0x8000000B, mepc=0x80; with MIE=0 -> no trap, mip reads 0x800.
REQ-039 exc_valid=1 and irq_ext pending in same cycle with csr_we to mscratch -> exception cause taken, mscratch unchanged.
REQ-040 Write mtvec=0x203 -> reads 0x200; exc_valid pulsed during FLUSH -> ignored, single redirect.
REQ-041 rst=1 in REDIR -> next cycle redirect_valid=0, flush=0, busy=0, mepc=0.
